// File: rtl/conv_window_addr_gen.sv
// Sliding-window tap sequencer: walks output pixels and kernel taps, emitting buffer/weight/psum addresses.
// Optional zero-padding support is enabled by defining CONV_WIN_PAD_EN.
module conv_window_addr_gen #(
  parameter int IMG_W  = 5,
  parameter int K_W    = 3,
  parameter int S_W    = 2,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [IMG_W-1:0]    image_size,
  input  logic [K_W-1:0]      kernel_size,
  input  logic [S_W-1:0]      stride,
  input  logic                tap_ready,
  output logic                tap_valid,
  output logic [ADDR_W-1:0]   in_addr,
  output logic [2*K_W-1:0]    w_addr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                first_tap,
  output logic                last_tap,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [IMG_W-1:0]    out_dim
`ifdef CONV_WIN_PAD_EN
  ,
  input  logic [K_W-2:0]      cfg_pad,
  output logic                tap_pad
`endif
);

  localparam int CW = ADDR_W + 2;
  localparam int WW = 2 * K_W;
  localparam int SP = IMG_W + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [IMG_W-1:0] img_q, img_d, od_q, od_d, ocol_q, ocol_d, orow_q, orow_d;
  logic [K_W-1:0]   k_q, k_d, kc_q, kc_d, kr_q, kr_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [K_W-2:0]   pad_q, pad_d, pad_in;
  logic             cfg_err_q, cfg_err_d;

`ifdef CONV_WIN_PAD_EN
  assign pad_in = cfg_pad;
`else
  assign pad_in = '0;
`endif

  // Start-time config check and output dimension, evaluated on the raw inputs
  logic [SP-1:0]    span, div;
  logic             cfg_ok;
  logic [IMG_W-1:0] od_new;

  assign span   = SP'(image_size) + (SP'(pad_in) << 1);
  assign div    = (stride == '0) ? SP'(1) : SP'(stride);
  assign cfg_ok = (kernel_size != '0) && (stride != '0) && (SP'(kernel_size) <= span);
  assign od_new = IMG_W'((span - SP'(kernel_size)) / div + SP'(1));

  logic run, fire, kc_max, kr_max, oc_max, or_max;

  assign run    = (state_q == ST_RUN);
  assign fire   = run && tap_ready && !abort;
  assign kc_max = (kc_q == k_q - K_W'(1));
  assign kr_max = (kr_q == k_q - K_W'(1));
  assign oc_max = (ocol_q == od_q - IMG_W'(1));
  assign or_max = (orow_q == od_q - IMG_W'(1));

  always_comb begin
    state_d   = state_q;
    img_d     = img_q;
    k_d       = k_q;
    s_d       = s_q;
    pad_d     = pad_q;
    od_d      = od_q;
    kc_d      = kc_q;
    kr_d      = kr_q;
    ocol_d    = ocol_q;
    orow_d    = orow_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = ST_RUN;
            img_d   = image_size;
            k_d     = kernel_size;
            s_d     = stride;
            pad_d   = pad_in;
            od_d    = od_new;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          kc_d    = '0;
          kr_d    = '0;
          ocol_d  = '0;
          orow_d  = '0;
          od_d    = '0;
        end else if (fire) begin
          // Counters wrap to zero on the final tap, leaving a clean state for the next frame
          if (kc_max) begin
            kc_d = '0;
            if (kr_max) begin
              kr_d = '0;
              if (oc_max) begin
                ocol_d = '0;
                if (or_max) begin
                  orow_d  = '0;
                  state_d = ST_DONE;
                end else begin
                  orow_d = orow_q + IMG_W'(1);
                end
              end else begin
                ocol_d = ocol_q + IMG_W'(1);
              end
            end else begin
              kr_d = kr_q + K_W'(1);
            end
          end else begin
            kc_d = kc_q + K_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) od_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      img_q     <= '0;
      k_q       <= '0;
      s_q       <= '0;
      pad_q     <= '0;
      od_q      <= '0;
      kc_q      <= '0;
      kr_q      <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      k_q       <= k_d;
      s_q       <= s_d;
      pad_q     <= pad_d;
      od_q      <= od_d;
      kc_q      <= kc_d;
      kr_q      <= kr_d;
      ocol_q    <= ocol_d;
      orow_q    <= orow_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Negative coordinates wrap to large unsigned values, so one compare catches both edges
  logic [CW-1:0] in_row, in_col, in_lin;
  logic          oob;

  assign in_row = CW'(orow_q) * CW'(s_q) + CW'(kr_q) - CW'(pad_q);
  assign in_col = CW'(ocol_q) * CW'(s_q) + CW'(kc_q) - CW'(pad_q);
  assign oob    = (in_row >= CW'(img_q)) || (in_col >= CW'(img_q));
  assign in_lin = in_row * CW'(img_q) + in_col;

  assign tap_valid = run;
  assign in_addr   = (run && !oob) ? ADDR_W'(in_lin) : '0;
  assign w_addr    = run ? (WW'(kr_q) * WW'(k_q) + WW'(kc_q)) : '0;
  assign out_addr  = run ? (ADDR_W'(orow_q) * ADDR_W'(od_q) + ADDR_W'(ocol_q)) : '0;
  assign first_tap = run && (kc_q == '0) && (kr_q == '0);
  assign last_tap  = run && kc_max && kr_max;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;
  assign out_dim   = od_q;
`ifdef CONV_WIN_PAD_EN
  assign tap_pad   = run && oob;
`endif

endmodule
